// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-level UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} uart_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam int   DATA_BITS = 8;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and flags the last clock of each bit period.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_serial.sv
// UART transmitter, 8N1 LSB first with a one-cycle done pulse per frame.
// Define UART_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_serial
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_send,
  input  logic [7:0] send_data,
  output logic       uart_send_done,
  output logic       txd,
  output logic       busy
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_serial: DIV must be >= 2");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_q, bit_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick, clr;
`ifdef UART_PARITY_EN
  logic        par_q, par_d;
`endif

  // Counter held at zero outside the timed states so START always gets a full period.
  assign clr = (state_q == IDLE) || (state_q == DONE);

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d  = LINE_IDLE;
        busy_d = 1'b0;
        if (uart_send) begin
          state_d = START;
          shreg_d = send_data;
          bit_d   = '0;
          txd_d   = START_BIT;
          busy_d  = 1'b1;
`ifdef UART_PARITY_EN
          par_d   = ^send_data;
`endif
        end
      end
      START: if (tick) begin
        state_d = DATA;
        txd_d   = shreg_q[0];
      end
      DATA: if (tick) begin
        if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
          txd_d   = par_q;
`else
          state_d = STOP;
          txd_d   = LINE_IDLE;
`endif
        end else begin
          bit_d   = bit_q + 3'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          txd_d   = shreg_q[1];
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) begin
        state_d = STOP;
        txd_d   = LINE_IDLE;
      end
`endif
      STOP: if (tick) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        txd_d   = LINE_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        txd_d   = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      txd_q   <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd            = txd_q;
  assign busy           = busy_q;
  assign uart_send_done = done_q;
endmodule

// File: tb/tb_uart_tx_serial.sv
// Directed bench for uart_tx_serial at DIV=10: every frame cycle checked against a hand-built bit table.
module tb_uart_tx_serial;
  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_send = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       uart_send_done, txd, busy;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int d0;

  uart_tx_serial #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_send      (uart_send),
    .send_data      (send_data),
    .uart_send_done (uart_send_done),
    .txd            (txd),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (uart_send_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line level for frame bit slot idx: start, 8 data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Caller sets uart_send/send_data at a negedge; accept happens on the next posedge.
  task automatic run_frame(input logic [7:0] b, input logic keep_req,
                           input logic [7:0] late, input int abort_k);
    int n;
    n = 0;
    @(negedge clk);
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, busy}, 32'd1);
    if (!keep_req) uart_send = 1'b0;
    send_data = late;
    for (int k = 0; k < DIV * NBITS; k++) begin
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        chk("rst_async", {busy, uart_send_done, txd}, 3'b001);
        return;
      end
      chk($sformatf("frame%0h_bit%0d", b, k / DIV), {busy, uart_send_done, txd},
          {2'b10, frame_bit(b, k / DIV)});
      @(negedge clk);
    end
    chk("done_pulse", {busy, uart_send_done, txd}, 3'b111);
    @(negedge clk);
    chk("post_done", {busy, uart_send_done, txd}, 3'b001);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("in_reset", {busy, uart_send_done, txd}, 3'b001);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle", {busy, uart_send_done, txd}, 3'b001);
    end

    uart_send = 1'b1; send_data = 8'hA5;
    run_frame(8'hA5, 1'b0, 8'hA5, -1);

    // Request held across DONE: two frames back to back.
    uart_send = 1'b1; send_data = 8'h00;
    run_frame(8'h00, 1'b1, 8'hFF, -1);
    run_frame(8'hFF, 1'b0, 8'hFF, -1);

    // Data changes after accept; line must keep the captured byte.
    uart_send = 1'b1; send_data = 8'h81;
    run_frame(8'h81, 1'b0, 8'h3C, -1);

    // Reset during data bit 4 (frame slot 5).
    d0 = done_cnt;
    uart_send = 1'b1; send_data = 8'h5A;
    run_frame(8'h5A, 1'b0, 8'h5A, 5 * DIV + 3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("idle_after_rst", {busy, uart_send_done, txd}, 3'b001);
    end
    chk("no_done_on_rst", done_cnt, d0);

    uart_send = 1'b1; send_data = 8'hC3;
    run_frame(8'hC3, 1'b0, 8'hC3, -1);
    uart_send = 1'b1; send_data = 8'h07;
    run_frame(8'h07, 1'b0, 8'h07, -1);
    uart_send = 1'b1; send_data = 8'h03;
    run_frame(8'h03, 1'b0, 8'h03, -1);

    chk("done_count", done_cnt, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
